id_ex_stage: RTL and testbench

ID/EX pipeline stage of the pipelined CPU, directly upstream of the ALU. Each cycle it latches one decoded instruction from the decode stage and resolves operand forwarding from the MEM and WB stages. It presents the ALU with final operands and the 3-bit ALU opcode, and detects load-use hazards, inserting a bubble and stalling the front end. It also handles flush on taken branches and hold on downstream memory stalls.

---
 rtl/id_ex_stage.sv | 207 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register sitting directly in front of the ALU.
//   - Latches one decoded instruction per cycle from the decode stage.
//   - Resolves operand forwarding from the EX/MEM and MEM/WB stages
//     (MEM has priority, register 0 is never forwarded).
//   - Selects the immediate or the forwarded rt value as ALU operand 2.
//   - Detects load-use hazards, inserts one bubble and stalls the front end.
//   - Flush (taken branch) loads a bubble; hold (downstream stall) freezes.
//
// Ports
//   clk, rst            : clock (rising edge), synchronous active-low reset
//   id_*                : decoded instruction from the ID stage
//   mem_regwrite/rd/result : EX/MEM forwarding source
//   wb_regwrite/rd/data    : MEM/WB forwarding source
//   flush, hold         : branch kill / downstream freeze
//   stall_out           : hold PC and IF/ID
//   ex_valid, alu_in1, alu_in2, alu_ctrl, ex_store_data,
//   ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg : EX slot outputs
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alusrc,
  input  logic              id_rt_used,
  input  logic [2:0]        id_aluctrl,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,

  input  logic              mem_regwrite,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0] mem_result,

  input  logic              wb_regwrite,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,

  input  logic              flush,
  input  logic              hold,

  output logic              stall_out,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_ctrl,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg
);

  // Stage registers
  logic              valid_q,    valid_d;
  logic [RA_W-1:0]   rs_q,       rs_d;
  logic [RA_W-1:0]   rt_q,       rt_d;
  logic [RA_W-1:0]   rd_q,       rd_d;
  logic [DATA_W-1:0] rs_data_q,  rs_data_d;
  logic [DATA_W-1:0] rt_data_q,  rt_data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic              alusrc_q,   alusrc_d;
  logic [2:0]        aluctrl_q,  aluctrl_d;
  logic              regwrite_q, regwrite_d;
  logic              memread_q,  memread_d;
  logic              memwrite_q, memwrite_d;
  logic              memtoreg_q, memtoreg_d;

  logic              hazard;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // Load-use: the load in EX cannot supply its data until it reaches WB,
  // so a dependent instruction in ID must wait one cycle. A bubble has
  // valid/memread cleared and therefore never raises this.
  always_comb begin
    hazard = valid_q && memread_q && (rd_q != '0) && id_valid &&
             ((rd_q == id_rs) || (id_rt_used && (rd_q == id_rt)));
  end

  assign stall_out = hold | (hazard & ~flush);

  // Next-state selection: flush > hold > hazard bubble > load.
  always_comb begin
    valid_d    = valid_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    alusrc_d   = alusrc_q;
    aluctrl_d  = aluctrl_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;

    if (flush || (!hold && hazard)) begin
      // Bubble: every field cleared.
      valid_d    = 1'b0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
      rs_data_d  = '0;
      rt_data_d  = '0;
      imm_d      = '0;
      alusrc_d   = 1'b0;
      aluctrl_d  = '0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
    end else if (!hold) begin
      valid_d    = id_valid;
      rs_d       = id_rs;
      rt_d       = id_rt;
      rd_d       = id_rd;
      rs_data_d  = id_rs_data;
      rt_data_d  = id_rt_data;
      imm_d      = id_imm;
      alusrc_d   = id_alusrc;
      aluctrl_d  = id_aluctrl;
      // An empty decode slot must not write registers or memory.
      regwrite_d = id_valid & id_regwrite;
      memread_d  = id_valid & id_memread;
      memwrite_d = id_valid & id_memwrite;
      memtoreg_d = id_valid & id_memtoreg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluctrl_q  <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      aluctrl_q  <= aluctrl_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
    end
  end

  // Forwarding mux per source path; MEM is the younger producer so it wins.
  always_comb begin
    fwd_rs = rs_data_q;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs_q)) begin
      fwd_rs = mem_result;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs_q)) begin
      fwd_rs = wb_data;
    end
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == rt_q)) begin
      fwd_rt = mem_result;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rt_q)) begin
      fwd_rt = wb_data;
    end
  end

  assign alu_in1       = fwd_rs;
  assign alu_in2       = alusrc_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_ctrl      = aluctrl_q;
  assign ex_valid      = valid_q;
  assign ex_rd         = rd_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_memtoreg   = memtoreg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed-vector bench for id_ex_stage: forwarding priority, immediate
//   select, load-use bubble, hold/flush interaction and reset mid-stall.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alusrc, id_rt_used;
  logic [2:0]  id_aluctrl;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        mem_regwrite;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, hold;
  logic        stall_out, ex_valid;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [2:0]  alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

  int unsigned total;
  int unsigned bad;

  id_ex_stage #(.DATA_W(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_rt_used(id_rt_used), .id_aluctrl(id_aluctrl),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .hold(hold),
    .stall_out(stall_out), .ex_valid(ex_valid),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one decoded instruction: rd, rs, rt, rs_data, rt_data, control.
  task automatic set_instr(input logic v, input logic [4:0] rd,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic [31:0] rsd, input logic [31:0] rtd,
                           input logic rt_used, input logic mr,
                           input logic [2:0] ctrl);
    id_valid    = v;
    id_rd       = rd;
    id_rs       = rs;
    id_rt       = rt;
    id_rs_data  = rsd;
    id_rt_data  = rtd;
    id_imm      = 32'h0;
    id_alusrc   = 1'b0;
    id_rt_used  = rt_used;
    id_aluctrl  = ctrl;
    id_regwrite = 1'b1;
    id_memread  = mr;
    id_memwrite = 1'b0;
    id_memtoreg = mr;
  endtask

  task automatic clr_fwd();
    mem_regwrite = 1'b0; mem_rd = '0; mem_result = '0;
    wb_regwrite  = 1'b0; wb_rd  = '0; wb_data    = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0; flush = 1'b0; hold = 1'b0;
    clr_fwd();
    set_instr(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
    id_regwrite = 1'b0;

    // Reset state
    tick();
    check_val("rst_valid", {31'd0, ex_valid}, 32'd0);
    check_val("rst_in1", alu_in1, 32'd0);
    check_val("rst_in2", alu_in2, 32'd0);
    check_val("rst_stall", {31'd0, stall_out}, 32'd0);
    check_val("rst_rd", {27'd0, ex_rd}, 32'd0);
    check_val("rst_store", ex_store_data, 32'd0);
    rst = 1'b1;

    // add r3,r1,r2 ; then sub r4,r3,r1 with r3 forwarded from MEM
    set_instr(1'b1, 5'd3, 5'd1, 5'd2, 32'h5, 32'h7, 1'b1, 1'b0, 3'b010);
    tick();
    check_val("add_valid", {31'd0, ex_valid}, 32'd1);
    check_val("add_rd", {27'd0, ex_rd}, 32'd3);
    check_val("add_in1", alu_in1, 32'h5);
    check_val("add_in2", alu_in2, 32'h7);
    check_val("add_ctrl", {29'd0, alu_ctrl}, 32'd2);
    set_instr(1'b1, 5'd4, 5'd3, 5'd1, 32'h99, 32'h22, 1'b1, 1'b0, 3'b110);
    #1;
    check_val("sub_nostall", {31'd0, stall_out}, 32'd0);
    tick();
    mem_regwrite = 1'b1; mem_rd = 5'd3; mem_result = 32'h10;
    #1;
    check_val("sub_fwd_in1", alu_in1, 32'h10);
    check_val("sub_in2", alu_in2, 32'h22);
    check_val("sub_ctrl", {29'd0, alu_ctrl}, 32'd6);

    // Double match on rs=5: MEM wins, then WB alone, then r0 never forwarded
    set_instr(1'b1, 5'd8, 5'd5, 5'd6, 32'h1111, 32'h2222, 1'b1, 1'b0, 3'b010);
    tick();
    mem_regwrite = 1'b1; mem_rd = 5'd5; mem_result = 32'hAAAA;
    wb_regwrite  = 1'b1; wb_rd  = 5'd5; wb_data    = 32'h5555;
    #1;
    check_val("dbl_mem_wins", alu_in1, 32'hAAAA);
    check_val("dbl_rt_nofwd", alu_in2, 32'h2222);
    mem_regwrite = 1'b0;
    #1;
    check_val("wb_only", alu_in1, 32'h5555);
    set_instr(1'b1, 5'd8, 5'd0, 5'd6, 32'h3333, 32'h2222, 1'b1, 1'b0, 3'b010);
    tick();
    mem_regwrite = 1'b1; mem_rd = 5'd0; mem_result = 32'hAAAA;
    wb_regwrite  = 1'b1; wb_rd  = 5'd0; wb_data    = 32'h5555;
    #1;
    check_val("r0_nofwd", alu_in1, 32'h3333);

    // Immediate operand with rt forwarded from MEM for the store data
    clr_fwd();
    set_instr(1'b1, 5'd0, 5'd1, 5'd6, 32'h40, 32'h0, 1'b1, 1'b0, 3'b010);
    id_alusrc = 1'b1; id_imm = 32'hFFFFFFFC; id_memwrite = 1'b1;
    id_regwrite = 1'b0; id_memtoreg = 1'b0;
    tick();
    mem_regwrite = 1'b1; mem_rd = 5'd6; mem_result = 32'h1234;
    #1;
    check_val("imm_in2", alu_in2, 32'hFFFFFFFC);
    check_val("imm_store", ex_store_data, 32'h1234);
    check_val("imm_memwrite", {31'd0, ex_memwrite}, 32'd1);

    // Load-use: lw r2 then add r6,r2,r7 -> one bubble, then WB forward
    clr_fwd();
    set_instr(1'b1, 5'd2, 5'd1, 5'd0, 32'h100, 32'h0, 1'b0, 1'b1, 3'b010);
    tick();
    set_instr(1'b1, 5'd6, 5'd2, 5'd7, 32'hDEAD, 32'h8, 1'b1, 1'b0, 3'b010);
    #1;
    check_val("lu_stall", {31'd0, stall_out}, 32'd1);
    tick();
    check_val("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check_val("lu_bubble_rw", {31'd0, ex_regwrite}, 32'd0);
    check_val("lu_bubble_nostall", {31'd0, stall_out}, 32'd0);
    tick();
    wb_regwrite = 1'b1; wb_rd = 5'd2; wb_data = 32'h77;
    #1;
    check_val("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    check_val("lu_add_rd", {27'd0, ex_rd}, 32'd6);
    check_val("lu_add_in1", alu_in1, 32'h77);
    check_val("lu_add_nostall", {31'd0, stall_out}, 32'd0);

    // Hold with a pending hazard freezes the load, hazard re-evaluated later
    clr_fwd();
    set_instr(1'b1, 5'd2, 5'd1, 5'd0, 32'h100, 32'h0, 1'b0, 1'b1, 3'b010);
    tick();
    set_instr(1'b1, 5'd6, 5'd7, 5'd2, 32'h1, 32'h2, 1'b1, 1'b0, 3'b010);
    hold = 1'b1;
    tick();
    check_val("hold_rd", {27'd0, ex_rd}, 32'd2);
    check_val("hold_memread", {31'd0, ex_memread}, 32'd1);
    check_val("hold_stall", {31'd0, stall_out}, 32'd1);
    hold = 1'b0;
    #1;
    check_val("hold_drop_stall", {31'd0, stall_out}, 32'd1);
    // rt not used: no hazard on rt match
    id_rt_used = 1'b0;
    #1;
    check_val("rt_unused_nostall", {31'd0, stall_out}, 32'd0);
    id_rt_used = 1'b1;

    // Flush beats hazard: stall_out follows hold only
    flush = 1'b1;
    #1;
    check_val("flush_hz_stall", {31'd0, stall_out}, 32'd0);
    hold = 1'b1;
    #1;
    check_val("flush_hold_stall", {31'd0, stall_out}, 32'd1);
    tick();
    check_val("flush_valid", {31'd0, ex_valid}, 32'd0);
    check_val("flush_rd", {27'd0, ex_rd}, 32'd0);
    check_val("flush_ctrl", {28'd0, ex_regwrite, ex_memread, ex_memwrite,
                             ex_memtoreg}, 32'd0);
    flush = 1'b0; hold = 1'b0;

    // id_valid=0 loads control bits as 0
    set_instr(1'b0, 5'd9, 5'd1, 5'd2, 32'h1, 32'h2, 1'b1, 1'b1, 3'b010);
    tick();
    check_val("invalid_ctrl", {27'd0, ex_valid, ex_regwrite, ex_memread,
                               ex_memwrite, ex_memtoreg}, 32'd0);

    // Reset asserted during a load-use stall
    set_instr(1'b1, 5'd2, 5'd1, 5'd0, 32'h100, 32'h0, 1'b0, 1'b1, 3'b010);
    tick();
    set_instr(1'b1, 5'd6, 5'd2, 5'd7, 32'h55, 32'h66, 1'b1, 1'b0, 3'b010);
    #1;
    check_val("rst_pre_stall", {31'd0, stall_out}, 32'd1);
    rst = 1'b0;
    tick();
    check_val("rstmid_valid", {31'd0, ex_valid}, 32'd0);
    check_val("rstmid_stall", {31'd0, stall_out}, 32'd0);
    check_val("rstmid_in1", alu_in1, 32'd0);
    check_val("rstmid_rd", {27'd0, ex_rd}, 32'd0);
    rst = 1'b1;
    tick();
    check_val("after_rst_valid", {31'd0, ex_valid}, 32'd1);
    check_val("after_rst_rd", {27'd0, ex_rd}, 32'd6);
    check_val("after_rst_in1", alu_in1, 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
